// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding, default feedback taps and the
// LFSR step function also used by the upstream generator.
package prbs_pkg;

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } prbs_state_e;

   localparam logic [3:0] PRBS_TAPS_DEF = 4'b1100;

   // One left-shift LFSR step on the low `width` bits; feedback is the parity of the tapped bits.
   function automatic logic [31:0] lfsr_next(input logic [31:0] word,
                                             input logic [31:0] taps,
                                             input int unsigned width);
      logic [31:0] mask;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return {word[30:0], ^(word & taps)} & mask;
   endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter; increments one cycle after inc_i and holds at all-ones.
// No backpressure: inc_i is sampled every cycle, cleared only by rst.
module prbs_sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: self-seeds from data, locks after LOCK_CNT matches, flags mismatches; 1-cycle registered outputs.
// No backpressure: in_valid low freezes all state. PRBS_CHK_ZERO_DET_EN treats an all-zero word as lock-up.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int unsigned      WIDTH    = 4,
   parameter logic [WIDTH-1:0] TAPS     = WIDTH'(PRBS_TAPS_DEF),
   parameter int unsigned      LOCK_CNT = 4,
   parameter int unsigned      LOSS_CNT = 3,
   parameter int unsigned      CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned GW = $clog2(LOCK_CNT + 1);
   localparam int unsigned BW = $clog2(LOSS_CNT + 1);

   prbs_state_e      state_q, state_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [GW-1:0]    good_cnt_q, good_cnt_d;
   logic [BW-1:0]    bad_cnt_q, bad_cnt_d;
   logic             err_pulse_q, err_pulse_d;

   logic [WIDTH-1:0] nxt_ref, nxt_in;
   logic             match, zero_word;

   assign nxt_ref = WIDTH'(lfsr_next(32'(ref_q), 32'(TAPS), WIDTH));
   assign nxt_in  = WIDTH'(lfsr_next(32'(in_data), 32'(TAPS), WIDTH));
   assign match   = (in_data == ref_q);

`ifdef PRBS_CHK_ZERO_DET_EN
   assign zero_word = (in_data == '0);
`else
   assign zero_word = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      good_cnt_d  = good_cnt_q;
      bad_cnt_d   = bad_cnt_q;
      err_pulse_d = 1'b0;
      if (in_valid) begin
         case (state_q)
            ST_SEED: begin
               // A lock-up word would seed a sequence that never advances.
               if (!zero_word) begin
                  ref_d      = nxt_in;
                  good_cnt_d = '0;
                  state_d    = ST_HUNT;
               end
            end
            ST_HUNT: begin
               if (zero_word) begin
                  good_cnt_d = '0;
                  state_d    = ST_SEED;
               end else if (match) begin
                  ref_d = nxt_ref;
                  if (good_cnt_q == GW'(LOCK_CNT - 1)) begin
                     good_cnt_d = '0;
                     bad_cnt_d  = '0;
                     state_d    = ST_LOCKED;
                  end else begin
                     good_cnt_d = good_cnt_q + 1'b1;
                  end
               end else begin
                  ref_d      = nxt_in;
                  good_cnt_d = '0;
               end
            end
            ST_LOCKED: begin
               ref_d = nxt_ref;
               if (match && !zero_word) begin
                  bad_cnt_d = '0;
               end else begin
                  err_pulse_d = 1'b1;
                  if (zero_word || (bad_cnt_q == BW'(LOSS_CNT - 1))) begin
                     bad_cnt_d = '0;
                     state_d   = ST_SEED;
                  end else begin
                     bad_cnt_d = bad_cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = ST_SEED;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SEED;
         ref_q       <= '0;
         good_cnt_q  <= '0;
         bad_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         good_cnt_q  <= good_cnt_d;
         bad_cnt_q   <= bad_cnt_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   prbs_sat_counter #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (err_pulse_d),
      .count_o (err_count)
   );

   assign locked    = (state_q == ST_LOCKED);
   assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single error, loss/relock, valid gaps,
// counter saturation, zero-word handling and asynchronous reset.
module tb_prbs_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       locked;
   logic       err_pulse;
   logic [7:0] err_count;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int pos;
   int exp_cnt;

   // x^4+x^3+1 sequence starting at 0001, hand-stepped.
   logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

   prbs_checker dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Present one word around a single rising edge; outputs are read 1 time unit later.
   task automatic send(input logic v, input logic [3:0] d);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic relock(input string tag);
      for (int i = 0; i < 5; i++) begin
         send(1'b1, seq[i]);
         if (i == 3) chk({tag, "_not_yet"}, {31'd0, locked}, 32'd0);
      end
      chk({tag, "_locked"}, {31'd0, locked}, 32'd1);
      pos = 5;
   endtask

   task automatic corrupt_burst(input int n);
      for (int i = 0; i < n; i++) begin
         send(1'b1, seq[(pos + 1) % 15]);
         pos = (pos + 1) % 15;
         exp_cnt = (exp_cnt + 1 > 255) ? 255 : exp_cnt + 1;
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 4'h0;
      exp_cnt  = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
      chk("rst_count", {24'd0, err_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      relock("lock1");
      chk("lock1_count", {24'd0, err_count}, 32'd0);
      chk("lock1_pulse", {31'd0, err_pulse}, 32'd0);

      send(1'b1, 4'b0111);
      chk("single_pulse", {31'd0, err_pulse}, 32'd1);
      chk("single_count", {24'd0, err_count}, 32'd1);
      chk("single_locked", {31'd0, locked}, 32'd1);
      send(1'b1, 4'b1101);
      chk("after_pulse", {31'd0, err_pulse}, 32'd0);
      chk("after_count", {24'd0, err_count}, 32'd1);
      pos = 7;

      send(1'b0, 4'h0);
      chk("gap0_pulse", {31'd0, err_pulse}, 32'd0);
      send(1'b0, 4'hF);
      chk("gap1_pulse", {31'd0, err_pulse}, 32'd0);
      send(1'b0, 4'h3);
      chk("gap2_pulse", {31'd0, err_pulse}, 32'd0);
      chk("gap_locked", {31'd0, locked}, 32'd1);
      chk("gap_count", {24'd0, err_count}, 32'd1);
      send(1'b1, seq[pos]);
      pos = pos + 1;
      chk("post_gap_pulse", {31'd0, err_pulse}, 32'd0);

      exp_cnt = 1;
      corrupt_burst(1);
      chk("loss1_pulse", {31'd0, err_pulse}, 32'd1);
      chk("loss1_locked", {31'd0, locked}, 32'd1);
      corrupt_burst(1);
      chk("loss2_pulse", {31'd0, err_pulse}, 32'd1);
      chk("loss2_locked", {31'd0, locked}, 32'd1);
      corrupt_burst(1);
      chk("loss3_pulse", {31'd0, err_pulse}, 32'd1);
      chk("loss3_locked", {31'd0, locked}, 32'd0);
      chk("loss_count", {24'd0, err_count}, 32'd4);

      relock("lock2");
      chk("lock2_count", {24'd0, err_count}, 32'd4);

      send(1'b1, 4'h0);
      exp_cnt = 5;
      chk("zero_pulse", {31'd0, err_pulse}, 32'd1);
      chk("zero_count", {24'd0, err_count}, 32'd5);
`ifdef PRBS_CHK_ZERO_DET_EN
      chk("zero_locked", {31'd0, locked}, 32'd0);
      relock("lock3");
`else
      chk("zero_locked", {31'd0, locked}, 32'd1);
      send(1'b1, seq[6]);
      chk("zero_next_pulse", {31'd0, err_pulse}, 32'd0);
      pos = 7;
`endif

      for (int b = 0; b < 84; b++) begin
         corrupt_burst(3);
         for (int i = 0; i < 5; i++) send(1'b1, seq[i]);
         pos = 5;
      end
      chk("sat_count", {24'd0, err_count}, 32'd255);
      chk("sat_model", {24'd0, err_count}, exp_cnt);
      chk("sat_locked", {31'd0, locked}, 32'd1);
      corrupt_burst(1);
      chk("sat_pulse", {31'd0, err_pulse}, 32'd1);
      chk("sat_hold", {24'd0, err_count}, 32'd255);

      #2;
      rst = 1'b1;
      #1;
      chk("arst_locked", {31'd0, locked}, 32'd0);
      chk("arst_count", {24'd0, err_count}, 32'd0);
      chk("arst_pulse", {31'd0, err_pulse}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      send(1'b1, seq[3]);
      send(1'b1, seq[10]);
      chk("hunt_miss_pulse", {31'd0, err_pulse}, 32'd0);
      chk("hunt_miss_count", {24'd0, err_count}, 32'd0);
      for (int i = 11; i < 15; i++) begin
         send(1'b1, seq[i]);
         if (i == 13) chk("reseed_not_yet", {31'd0, locked}, 32'd0);
      end
      chk("reseed_locked", {31'd0, locked}, 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Downstream consumer of the 4-bit LFSR pseudo-random generator. It takes the generator's parallel state word each valid cycle and self-synchronises to the sequence by seeding its own reference LFSR from received data. It then flags every word that deviates from the predicted sequence. It sits at the receive end of a PRBS link test, and its outputs feed status and error-logging logic.

## Interface
- `WIDTH`, 4: LFSR/word width.
- `TAPS`, 4'b1100: feedback mask; fb = ^(word & TAPS), next = {word[WIDTH-2:0], fb} (x^4+x^3+1, matches upstream generator).
- `LOCK_CNT`, 4: consecutive matches in HUNT required to lock.
- `LOSS_CNT`, 3: consecutive mismatches in LOCKED that drop lock.
- `CNT_W`, 8: error counter width.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  in_data valid this cycle.
- `in_data`  input  WIDTH  received LFSR word.
- `locked`  output  1  checker synchronised to sequence.
- `err_pulse`  output  1  one-cycle pulse per mismatching word while LOCKED.
- `err_count`  output  CNT_W  saturating count of errors since reset.

## Operation
- States: SEED, HUNT, LOCKED. Reset enters SEED; reference register `ref` = 0, good_cnt = bad_cnt = 0.
- in_valid low: no state, counter or `ref` change in any state.
- SEED: first valid word loads ref <= next(in_data); go to HUNT, good_cnt = 0.
- HUNT: compare in_data with ref.
  - Match: good_cnt++, ref <= next(ref). When good_cnt reaches LOCK_CNT, go to LOCKED and set bad_cnt = 0.
  - Mismatch: reseed with ref <= next(in_data), good_cnt = 0.
  - No err_pulse and no err_count change in HUNT.
- LOCKED: ref <= next(ref) on every valid word; ref is free-running and is never reseeded from data.
  - Match: bad_cnt = 0.
  - Mismatch: err_pulse, err_count++ (saturates at all-ones), bad_cnt++. When bad_cnt reaches LOSS_CNT, go to SEED.
- A mismatch that drops lock is itself counted.
- err_count clears only on rst.

## Timing
- Reset values: locked = 0, err_pulse = 0, err_count = 0.
- All outputs are registered. Latency is 1 cycle: err_pulse and err_count reflect the word sampled on the previous rising edge.
- locked rises the cycle after the LOCK_CNT-th matching word. It falls the cycle after the LOSS_CNT-th consecutive mismatch.
- err_pulse is never high for two cycles unless two consecutive valid mismatching words arrive.
- Reset asserted mid-operation clears everything asynchronously. The first valid word after release seeds.

## Configuration
- `PRBS_CHK_ZERO_DET_EN` defined: an all-zero in_data word (LFSR lock-up state) is always a mismatch. In HUNT it forces SEED rather than reseeding. In LOCKED it counts an error and immediately forces SEED (locked falls next cycle) regardless of bad_cnt.
- Undefined: an all-zero word is compared like any other word.

## Structure
- The shared package `prbs_pkg` holds the state enum (SEED/HUNT/LOCKED), the default TAPS constant, and a `lfsr_next(word, taps)` function shared with the generator.
- One sub-module, `prbs_sat_counter`: CNT_W-bit saturating incrementer with async reset, used for err_count.

## Test plan
- Reset release, then generator words 0001, 0010, 0100, 1001, 0011 on consecutive valid cycles -> locked = 1 the cycle after 0011; err_count = 0.
- While locked, expected 0110 is replaced by 0111 once -> one err_pulse, err_count = 1, locked stays 1; the next correct word 1101 is accepted.
- While locked, 3 consecutive corrupted words -> err_count += 3, locked = 0 after the third; a clean sequence then relocks after 5 valid words.
- in_valid toggled low for 3 cycles mid-sequence with in_data garbage -> no err_pulse, no state change.
- err_count forced to 255 by repeated errors (relocking between bursts) -> stays 255 on further errors.
- All-zero word while locked with `PRBS_CHK_ZERO_DET_EN` -> err_pulse, locked = 0 next cycle. Without the macro -> err_pulse only, locked stays 1.
